config_frame_loader: RTL
========================

CONFIG_FRAME_LOADER -- requirements
Module: config_frame_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the configuration write word.
REQ-002 SHALL have parameter FRAME_BITS, default 64, bits per frame; an integer multiple of DATA_W, at least DATA_W.
REQ-003 SHALL have parameter NUM_FRAMES, default 20, number of frames; range 1..2^(DATA_W-8).
REQ-004 SHALL derive local FRAME_WORDS = FRAME_BITS/DATA_W and ADDR_W = max(1, clog2(NUM_FRAMES)).
REQ-005 SHALL have a single clock and an asynchronous, active-high reset.
REQ-006 CLK  in  1  single clock; all state changes on the rising edge.
REQ-007 RST  in  1  asynchronous active-high reset.
REQ-008 cfg_valid  in  1  word offered on cfg_data.
REQ-009 cfg_data  in  DATA_W  header or payload word.
REQ-010 cfg_ready  out  1  block accepts a word this cycle.
REQ-011 err_clr  in  1  clears the sticky error.
REQ-012 cfg_q  out  NUM_FRAMES*FRAME_BITS  configuration bits; frame f occupies [f*FRAME_BITS +: FRAME_BITS].
REQ-013 cfg_qn  out  NUM_FRAMES*FRAME_BITS  bitwise complement of cfg_q at all times.
REQ-014 frame_done  out  1  one-cycle pulse on a frame commit.
REQ-015 err  out  1  sticky error flag.
REQ-016 err_code  out  2  01 bad sync, 10 address out of range; holds the last error.

Function
REQ-017 A word SHALL transfer only when cfg_valid and cfg_ready are both high on a rising CLK edge.
REQ-018 State machine SHALL use states IDLE, LOAD, DISCARD and COMMIT.
REQ-019 cfg_ready SHALL be high in IDLE, LOAD and DISCARD, and low in COMMIT.
REQ-020 IDLE: an accepted word is a header; sync = cfg_data[DATA_W-1 -: 8], addr = cfg_data[ADDR_W-1:0], other bits ignored.
REQ-021 IDLE: sync != 8'hFA -> stay in IDLE, word dropped, err=1, err_code=01.
REQ-022 IDLE: sync ok and addr < NUM_FRAMES -> latch addr, clear word counter, go to LOAD.
REQ-023 IDLE: sync ok and addr >= NUM_FRAMES -> err=1, err_code=10, go to DISCARD.
REQ-024 LOAD: accepted word k (0-based) SHALL be written into staging buffer bits [k*DATA_W +: DATA_W]; LSB word first.
REQ-025 LOAD: after word FRAME_WORDS-1 is accepted, go to COMMIT.
REQ-026 DISCARD: accept and drop FRAME_WORDS words, then return to IDLE; cfg_q SHALL be unchanged.
REQ-027 COMMIT (exactly one cycle): the frame at the latched address SHALL be updated atomically from staging, frame_done SHALL pulse, then go to IDLE.
REQ-028 The new frame value SHALL be visible on cfg_q/cfg_qn the cycle after COMMIT; latency from last payload word to visible data is 2 edges.
REQ-029 A partially loaded frame SHALL never appear on cfg_q; all other frames SHALL be unchanged by a commit.
REQ-030 Stalls (cfg_valid low) in any state SHALL hold the state, counter and staging buffer.
REQ-031 Same-cycle err_clr and a new error: the new error SHALL win (err=1, err_code updated).
REQ-032 err_clr alone SHALL clear err and err_code to 0 on the next edge; it SHALL not affect the state machine.
REQ-033 Word counter SHALL wrap to 0 on entry to LOAD/DISCARD; no overflow past FRAME_WORDS-1.

Reset
REQ-034 RST high SHALL immediately force IDLE, counter=0, staging=0, cfg_q all 0, cfg_qn all 1, frame_done=0, err=0, err_code=00, cfg_ready=0.
REQ-035 cfg_ready SHALL rise on the first CLK edge after RST deasserts.
REQ-036 RST mid-frame SHALL discard the partial frame; no commit occurs.

Verification
REQ-037 Defaults; header 0xFA000003, payload 0x11111111, 0x22222222 -> frame_done pulse, cfg_q[255:192]=0x2222222211111111, cfg_qn[255:192]=0xDDDDDDDDEEEEEEEE, other frames 0.
REQ-038 Header 0x12000001 -> err=1, err_code=01, state stays IDLE; next header 0xFA000001 plus 2 words loads frame 1 normally.
REQ-039 Header 0xFA000014 (addr 20) plus 2 words -> err_code=10, no frame_done, cfg_q unchanged; then err_clr -> err=0, err_code=00.
REQ-040 Load frame 0 with cfg_valid toggling every other cycle -> same result as back-to-back; cfg_ready low only in the COMMIT cycle.
REQ-041 Header 0xFA000005 plus 1 word, then RST pulse -> cfg_q all 0, cfg_qn all 1; a fresh load of frame 5 succeeds.
REQ-042 err_clr coincident with bad header 0x00000000 -> err stays 1, err_code=01.

Source files
------------

// File: rtl/config_frame_loader.sv
// rtl/config_frame_loader.sv - header-addressed configuration frame loader with staged atomic commit
module config_frame_loader #(
    parameter int DATA_W     = 32,
    parameter int FRAME_BITS = 64,
    parameter int NUM_FRAMES = 20
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             cfg_valid,
    input  logic [DATA_W-1:0]                cfg_data,
    output logic                             cfg_ready,
    input  logic                             err_clr,
    output logic [NUM_FRAMES*FRAME_BITS-1:0] cfg_q,
    output logic [NUM_FRAMES*FRAME_BITS-1:0] cfg_qn,
    output logic                             frame_done,
    output logic                             err,
    output logic [1:0]                       err_code
);

    localparam int FRAME_WORDS = FRAME_BITS / DATA_W;
    localparam int ADDR_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int CNT_W       = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int TOTAL_BITS  = NUM_FRAMES * FRAME_BITS;

    localparam logic [ADDR_W:0]  NUM_FRAMES_W = (ADDR_W + 1)'(NUM_FRAMES);
    localparam logic [CNT_W-1:0] LAST_WORD    = CNT_W'(FRAME_WORDS - 1);
    localparam logic [7:0]       SYNC_BYTE    = 8'hFA;
    localparam logic [1:0]       CODE_SYNC    = 2'b01;
    localparam logic [1:0]       CODE_RANGE   = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DISCARD,
        COMMIT
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [FRAME_BITS-1:0]   stage_q, stage_d;
    logic [TOTAL_BITS-1:0]   frames_q, frames_d;
    logic                    ready_q, ready_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [1:0]              code_q, code_d;

    logic                    xfer;
    logic [7:0]              hdr_sync;
    logic [ADDR_W-1:0]       hdr_addr;
    logic                    err_set;
    logic [1:0]              err_set_code;
    logic                    unused_cfg_bits;

    assign xfer            = cfg_valid & ready_q;
    assign hdr_sync        = cfg_data[DATA_W-1 -: 8];
    assign hdr_addr        = cfg_data[ADDR_W-1:0];
    assign unused_cfg_bits = ^cfg_data;

    assign cfg_ready  = ready_q;
    assign cfg_q      = frames_q;
    assign cfg_qn     = ~frames_q;
    assign frame_done = done_q;
    assign err        = err_q;
    assign err_code   = code_q;

    // Next-state logic: header decode, payload staging, discard counting and commit
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        stage_d      = stage_q;
        frames_d     = frames_q;
        err_set      = 1'b0;
        err_set_code = 2'b00;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (hdr_sync != SYNC_BYTE) begin
                        err_set      = 1'b1;
                        err_set_code = CODE_SYNC;
                    end else if ({1'b0, hdr_addr} < NUM_FRAMES_W) begin
                        addr_d  = hdr_addr;
                        cnt_d   = '0;
                        state_d = LOAD;
                    end else begin
                        err_set      = 1'b1;
                        err_set_code = CODE_RANGE;
                        cnt_d        = '0;
                        state_d      = DISCARD;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    stage_d[int'(cnt_q) * DATA_W +: DATA_W] = cfg_data;
                    if (cnt_q == LAST_WORD) begin
                        cnt_d   = '0;
                        state_d = COMMIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (xfer) begin
                    if (cnt_q == LAST_WORD) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            COMMIT: begin
                // The whole staged frame lands in one edge, so no partial frame is ever visible.
                frames_d[int'(addr_q) * FRAME_BITS +: FRAME_BITS] = stage_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs: ready drops only for the commit cycle; a new error beats a clear
    always_comb begin
        ready_d = (state_d != COMMIT);
        done_d  = (state_d == COMMIT);
        err_d   = err_q;
        code_d  = code_q;
        if (err_set) begin
            err_d  = 1'b1;
            code_d = err_set_code;
        end else if (err_clr) begin
            err_d  = 1'b0;
            code_d = 2'b00;
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            stage_q  <= '0;
            frames_q <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            stage_q  <= stage_d;
            frames_q <= frames_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

endmodule
